// File: rtl/vga_text_pkg.sv
// Shared constants, clear-sequencer state encoding and the 8x8 font ROM
// used by the character-tile renderer.
package vga_text_pkg;

    localparam int TILE_COLS = 32;
    localparam int GLYPH_W   = 8;
    localparam int GLYPH_H   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    // 256 x 8 font table indexed by {glyph[4:0], glyph_row[2:0]}; MSB is the leftmost pixel.
    function automatic logic [7:0] font_byte(input logic [7:0] idx);
        logic [4:0] glyph;
        logic [2:0] line;
        glyph = idx[7:3];
        line  = idx[2:0];
        case (glyph)
            5'd0:    font_byte = 8'h00;
            5'd1:    font_byte = 8'hFF;
            5'd2:    font_byte = line[0] ? 8'h55 : 8'hAA;
            default: font_byte = {glyph, line} ^ {line, glyph};
        endcase
    endfunction

endpackage

// File: rtl/tile_ram_sdp.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// A same-address read and write in one cycle returns the previous contents.
module tile_ram_sdp #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/vga_text_render.sv
// 32x32 grid of 8x8 glyphs rendered into a 256x256 window, with a host
// write port into the tile RAM and a full-screen clear sequencer.
module vga_text_render
    import vga_text_pkg::*;
#(
    parameter int GLYPHS  = 32,
    parameter int TILE_AW = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [7:0]         iCol,
    input  logic [7:0]         iRow,
    input  logic               iWrEn,
    input  logic [TILE_AW-1:0] iWrAddr,
    input  logic [7:0]         iWrData,
    input  logic               iClear,
    output logic               oWrReady,
    output logic               oClearDone,
    output logic               oR,
    output logic               oG,
    output logic               oB
);

    localparam int CODE_W = $clog2(GLYPHS);

    state_t             state;
    logic [TILE_AW-1:0] clr_cnt;
    logic               ready_q;
    logic               done_q;

    logic               ram_we;
    logic [TILE_AW-1:0] ram_wa;
    logic [7:0]         ram_wd;

    logic               vld_p0, vld_p1, vld_p2;
    logic [7:0]         col_p0, row_p0;
    logic [2:0]         xsub_p1, ysub_p1, xsub_p2;
    logic [7:0]         tile_p1;
    logic [7:0]         bits_p2;
    logic [2:0]         rgb_p2;

    function automatic logic pixel_bit(input logic [7:0] bits, input logic [2:0] x);
        return bits[3'(GLYPH_W - 1) - x];
    endfunction

    // Ready is registered so it reads low throughout reset and during the DONE beat.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            clr_cnt <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            case (state)
                IDLE: begin
                    ready_q <= !iClear;
                    if (iClear) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == '1) begin
                        state <= DONE;
                    end else begin
                        clr_cnt <= clr_cnt + TILE_AW'(1);
                    end
                end
                DONE: begin
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign oWrReady   = ready_q;
    assign oClearDone = done_q;

    // A clear request in the same cycle as a host write discards the write.
    always_comb begin
        ram_we = 1'b0;
        ram_wa = iWrAddr;
        ram_wd = iWrData;
        if (state == CLEAR) begin
            ram_we = 1'b1;
            ram_wa = clr_cnt;
            ram_wd = 8'h00;
        end else if (iWrEn && ready_q && !iClear) begin
            ram_we = 1'b1;
        end
    end

    tile_ram_sdp #(
        .DATA_W(8),
        .ADDR_W(TILE_AW)
    ) u_tile_ram (
        .clock  (clock),
        .wr_en  (ram_we),
        .wr_addr(ram_wa),
        .wr_data(ram_wd),
        .rd_addr({row_p0[7:3], col_p0[7:3]}),
        .rd_data(tile_p1)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            vld_p0  <= 1'b0;
            col_p0  <= '0;
            row_p0  <= '0;
            vld_p1  <= 1'b0;
            xsub_p1 <= '0;
            ysub_p1 <= '0;
            vld_p2  <= 1'b0;
            bits_p2 <= '0;
            rgb_p2  <= '0;
            xsub_p2 <= '0;
            oR      <= 1'b0;
            oG      <= 1'b0;
            oB      <= 1'b0;
        end else begin
            // S0: capture window coordinates
            vld_p0  <= 1'b1;
            col_p0  <= iCol;
            row_p0  <= iRow;
            // S1: tile RAM read in flight, carry sub-tile offsets
            vld_p1  <= vld_p0;
            xsub_p1 <= col_p0[2:0];
            ysub_p1 <= row_p0[2:0];
            // S2: font row lookup
            vld_p2  <= vld_p1;
            bits_p2 <= font_byte({tile_p1[CODE_W-1:0], ysub_p1});
            rgb_p2  <= tile_p1[7:5];
            xsub_p2 <= xsub_p1;
            // S3: pixel select and colour
            oR      <= vld_p2 & pixel_bit(bits_p2, xsub_p2) & rgb_p2[2];
            oG      <= vld_p2 & pixel_bit(bits_p2, xsub_p2) & rgb_p2[1];
            oB      <= vld_p2 & pixel_bit(bits_p2, xsub_p2) & rgb_p2[0];
        end
    end

endmodule

// File: doc/vga_text_render.md
# vga_text_render

Character-tile pixel source that feeds the VGA timing controller's colour inputs (`iCrvgaR/G/B`). It takes the controller's current 256x256 window coordinates (`oCurrentCol`/`oCurrentRow`) and renders a 32x32 grid of 8x8 glyphs. Glyph codes and colours come from an internal 1024-entry tile RAM that the host writes through a ready/valid port. A clear sequencer blanks the whole screen on request.

## Interface
- `GLYPHS`, 32: number of glyphs in the font ROM, indexed by a 5-bit code.
- `TILE_AW`, 10: tile RAM address width (32 columns x 32 rows).
- `clock` in 1: system clock, the same clock as the timing controller.
- `reset` in 1: synchronous, active-low.
- `iCol` in 8: current window column, 0..255, from the timing controller.
- `iRow` in 8: current window row, 0..255, from the timing controller.
- `iWrEn` in 1: host write request (valid).
- `iWrAddr` in 10: tile address, computed as `{tileRow[4:0], tileCol[4:0]}`.
- `iWrData` in 8: tile entry. `[7:5]` is colour RGB, `[4:0]` is the glyph code.
- `iClear` in 1: one-cycle pulse that starts a full-screen clear.
- `oWrReady` out 1: high when a write is accepted this cycle.
- `oClearDone` out 1: one-cycle pulse when a clear completes.
- `oR`, `oG`, `oB` out 1 each: pixel colour, routed to `iCrvgaR/G/B`.

## Operation
- Tile RAM is simple dual-port: one synchronous write port and one synchronous read port, 1024 x 8. Contents are not reset.
- Render pipeline runs every cycle with no stalls:
  - S0 registers `iCol` and `iRow`.
  - S1 reads the tile RAM at `{row[7:3], col[7:3]}`.
  - S2 looks up the glyph row byte in the ROM at `{glyph[4:0], row[2:0]}`. `col[2:0]` and `row[2:0]` are carried alongside.
  - S3 selects the pixel bit as `byte[7 - col[2:0]]`. The bit (MSB = leftmost pixel) is ANDed with colour bits `[7:5]` into `oR`, `oG`, `oB`.
- Write port: a write happens on any cycle where `iWrEn && oWrReady`. `oWrReady` equals `(state == IDLE)`. If `iWrEn` is high while not ready, the write is dropped; the host must hold the request until ready.
- Clear FSM states:
  - `IDLE`: on `iClear`, go to `CLEAR` with the clear counter at 0.
  - `CLEAR`: write `8'h00` at the counter each cycle. When the counter reaches 1023, go to `DONE`.
  - `DONE`: assert `oClearDone` for one cycle, then return to `IDLE`.
- In `IDLE`, `iClear` together with `iWrEn` in the same cycle: the clear wins and the host write is not performed. `oWrReady` stays high that cycle, but the write is discarded.
- `iClear` while in `CLEAR` or `DONE` is ignored.
- Rendering continues during a clear. The display shows partially cleared content; this is acceptable.
- Read and write to the same address in the same cycle: the read returns the old data.
- The clear counter is 10 bits. It stops at 1023 and does not wrap.

## Timing
- Reset, with `reset` low at a clock edge:
  - state `IDLE`, clear counter 0.
  - `oR`, `oG`, `oB` = 0, `oClearDone` = 0, and all pipeline valid/data registers = 0.
  - `oWrReady` is 0 during reset and 1 on the first cycle after reset is released.
- Reset mid-clear aborts the clear. The RAM is left partially cleared and no `oClearDone` is produced.
- Render latency is 3 clocks, from `iCol`/`iRow` sampled at edge N to `oR/G/B` valid after edge N+3. The integrator compensates by offsetting the controller's window by 3.
- Clear takes 1024 write cycles. `oClearDone` pulses exactly 1025 cycles after the `iClear` edge. `oWrReady` returns high one cycle after `oClearDone`.
- A write accepted at edge N is visible to a render read issued at edge N+1 or later.

## Structure
- Package `vga_text_pkg`:
  - constants `TILE_COLS = 32`, `GLYPH_W = 8`, `GLYPH_H = 8`.
  - state encoding `IDLE = 2'd0`, `CLEAR = 2'd1`, `DONE = 2'd2`.
  - the 256 x 8 font ROM table: glyph 0 blank, glyph 1 solid `8'hFF`, glyph 2 checker `8'hAA`/`8'h55` alternating rows, the rest defined by the font file.
- One sub-module, `tile_ram_sdp`: parameterised simple dual-port RAM with a 1-cycle registered read. The FSM, render pipeline and ROM lookup stay in the top level.

## Test plan
- Reset, then write `iWrAddr=0`, `iWrData=8'b100_00001`, and sweep `iCol` 0..7 at `iRow=0`: `oR=1`, `oG=0`, `oB=0` for all 8 pixels, each 3 cycles after its input. Tile at `iCol=8` gives all zeros.
- Write `8'b111_00010` at address 33, then drive `iCol=8..15` with `iRow=8` and `iRow=9`: outputs show 1010_1010 on row 8 and 0101_0101 on row 9, white.
- Pulse `iClear` after filling RAM with `8'hE1`:
  - `oWrReady` drops the next cycle.
  - `oClearDone` pulses at +1025.
  - a full-screen sweep afterwards gives all-zero outputs.
- Assert `iClear` and `iWrEn` (address 5, `8'hE1`) in the same cycle: the clear completes and address 5 reads 0. A `iWrEn` held during `CLEAR` is accepted only after `oWrReady` returns.
- Pull `reset` low 100 cycles into a clear: outputs become 0, no `oClearDone` follows, and `oWrReady=1` one cycle after release.
- Write address 1023 at edge N and render `iCol=248`, `iRow=248` from edge N+1: the new glyph appears at N+4.
